ring_pattern_engine: RTL

Parametrised, pipelined concentric-ring pattern generator for the 640x480 VGA path. Consumes beam position, blanking and syncs from `hvsync_generator` and produces RGB222 plus pipeline-aligned syncs for the Tiny VGA PMOD mapping in the top level. It adds several features:

- Selectable ring shape.
- Multi-step speed.
- A ring centre that bounces around the screen.
- Control sampling once per frame so no frame tears.

---
 rtl/ring_pattern_engine_if.sv | 25 ++
 rtl/ring_pattern_engine.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ring_pattern_engine_if.sv
// rtl/ring_pattern_engine_if.sv - beam-position/sync in, RGB222/sync out video bundle
interface ring_pattern_engine_if #(
    parameter int COORD_W = 10
);
    logic [COORD_W-1:0] hpos;
    logic [COORD_W-1:0] vpos;
    logic               display_on;
    logic               hsync_in;
    logic               vsync_in;
    logic [1:0]         r;
    logic [1:0]         g;
    logic [1:0]         b;
    logic               hsync_out;
    logic               vsync_out;

    modport master (
        output hpos, vpos, display_on, hsync_in, vsync_in,
        input  r, g, b, hsync_out, vsync_out
    );

    modport slave (
        input  hpos, vpos, display_on, hsync_in, vsync_in,
        output r, g, b, hsync_out, vsync_out
    );
endinterface

// File: rtl/ring_pattern_engine.sv
// rtl/ring_pattern_engine.sv - two-stage concentric-ring RGB222 generator with bouncing centre
module ring_pattern_engine #(
    parameter int   H_ACTIVE      = 640,
    parameter int   V_ACTIVE      = 480,
    parameter int   COORD_W       = 10,
    parameter int   SPEED_W       = 3,
    parameter int   PHASE_W       = 8,
    parameter int   BOUNCE_MARGIN = 64,
    parameter logic SYNC_IDLE     = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] speed,
    input  logic               direction,
    input  logic [1:0]         shape,
    input  logic               bounce_en,
    ring_pattern_engine_if.slave vid
);
    localparam logic [COORD_W-1:0] X_MIN = COORD_W'(BOUNCE_MARGIN);
    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1 - BOUNCE_MARGIN);
    localparam logic [COORD_W-1:0] Y_MIN = COORD_W'(BOUNCE_MARGIN);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1 - BOUNCE_MARGIN);

    // Returns {next_dir, next_pos}; dir 0 = increasing. Bounces off a limit in the same tick.
    function automatic logic [COORD_W:0] step_axis(
        input logic [COORD_W-1:0] pos,
        input logic               dir,
        input logic [COORD_W-1:0] lo,
        input logic [COORD_W-1:0] hi
    );
        if (!dir) begin
            if (pos >= hi) step_axis = {1'b1, pos - 1'b1};
            else           step_axis = {1'b0, pos + 1'b1};
        end else begin
            if (pos <= lo) step_axis = {1'b0, pos + 1'b1};
            else           step_axis = {1'b1, pos - 1'b1};
        end
    endfunction

    logic               tick;
    logic [SPEED_W-1:0] speed_l;
    logic               direction_l;
    logic [1:0]         shape_l;
    logic               bounce_en_l;
    logic [SPEED_W-1:0] speed_n;
    logic               direction_n;
    logic [1:0]         shape_n;
    logic               bounce_en_n;
    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] step;
    logic [COORD_W-1:0] cx, cy;
    logic               x_dir, y_dir;
    logic [COORD_W:0]   x_next, y_next;

    assign tick = (vid.vpos == COORD_W'(V_ACTIVE)) && (vid.hpos == '0);

    // The controls present on the tick cycle are both captured and used for that tick's update.
    always_comb begin
        speed_n     = tick ? speed     : speed_l;
        direction_n = tick ? direction : direction_l;
        shape_n     = tick ? shape     : shape_l;
        bounce_en_n = tick ? bounce_en : bounce_en_l;
        step        = PHASE_W'(speed_n) + PHASE_W'(1);
        x_next      = step_axis(cx, x_dir, X_MIN, X_MAX);
        y_next      = step_axis(cy, y_dir, Y_MIN, Y_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            speed_l     <= '0;
            direction_l <= 1'b0;
            shape_l     <= '0;
            bounce_en_l <= 1'b0;
            phase       <= '0;
            cx          <= COORD_W'(H_ACTIVE / 2);
            cy          <= COORD_W'(V_ACTIVE / 2);
            x_dir       <= 1'b0;
            y_dir       <= 1'b0;
        end else begin
            speed_l     <= speed_n;
            direction_l <= direction_n;
            shape_l     <= shape_n;
            bounce_en_l <= bounce_en_n;
            if (tick) begin
                phase <= direction_n ? phase - step : phase + step;
                if (bounce_en_n) begin
                    {x_dir, cx} <= x_next;
                    {y_dir, cy} <= y_next;
                end
            end
        end
    end

    logic signed [COORD_W:0] dx, dy;
    logic [COORD_W-1:0]      abs_x, abs_y;
    logic [COORD_W-1:0]      s1_abs_x, s1_abs_y;
    logic                    s1_de, s1_hs, s1_vs;

    always_comb begin
        dx    = $signed({1'b0, vid.hpos}) - $signed({1'b0, cx});
        dy    = $signed({1'b0, vid.vpos}) - $signed({1'b0, cy});
        abs_x = dx[COORD_W] ? COORD_W'(-dx) : dx[COORD_W-1:0];
        abs_y = dy[COORD_W] ? COORD_W'(-dy) : dy[COORD_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_abs_x <= '0;
            s1_abs_y <= '0;
            s1_de    <= 1'b0;
            s1_hs    <= SYNC_IDLE;
            s1_vs    <= SYNC_IDLE;
        end else begin
            s1_abs_x <= abs_x;
            s1_abs_y <= abs_y;
            s1_de    <= vid.display_on;
            s1_hs    <= vid.hsync_in;
            s1_vs    <= vid.vsync_in;
        end
    end

    logic [COORD_W-1:0] mx, mn;
    logic [COORD_W:0]   radius;
    logic [3:0]         idx_hi;

    always_comb begin
        mx = (s1_abs_x >= s1_abs_y) ? s1_abs_x : s1_abs_y;
        mn = (s1_abs_x >= s1_abs_y) ? s1_abs_y : s1_abs_x;
        case (shape_l)
            2'd1:    radius = {1'b0, mx};
            2'd2:    radius = {1'b0, s1_abs_x} + {1'b0, s1_abs_y};
            default: radius = {1'b0, mx} + {2'b00, mn[COORD_W-1:1]};
        endcase
        // Only the upper nibble of the 8-bit colour index drives any colour bit.
        idx_hi = 4'((8'(radius) - 8'(phase)) >> 4);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vid.r         <= '0;
            vid.g         <= '0;
            vid.b         <= '0;
            vid.hsync_out <= SYNC_IDLE;
            vid.vsync_out <= SYNC_IDLE;
        end else begin
            vid.r         <= s1_de ? idx_hi[1:0] : 2'b00;
            vid.g         <= s1_de ? idx_hi[2:1] : 2'b00;
            vid.b         <= s1_de ? idx_hi[3:2] : 2'b00;
            vid.hsync_out <= s1_hs;
            vid.vsync_out <= s1_vs;
        end
    end
endmodule
